// File: rtl/video_timing_pkg.sv
// Shared encodings and colour constants for the video timing / test-pattern generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_STRIPE = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_TOGGLE = 2'd3
  } vtg_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } vtg_state_t;

  // Colours are packed {G,R,B}
  localparam logic [23:0] GRB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] GRB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] GRB_CYAN    = 24'hFF00FF;
  localparam logic [23:0] GRB_G       = 24'hFF0000;
  localparam logic [23:0] GRB_MAGENTA = 24'h00FFFF;
  localparam logic [23:0] GRB_R       = 24'h00FF00;
  localparam logic [23:0] GRB_B       = 24'h0000FF;
  localparam logic [23:0] GRB_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return GRB_WHITE;
      3'd1:    return GRB_YELLOW;
      3'd2:    return GRB_CYAN;
      3'd3:    return GRB_G;
      3'd4:    return GRB_MAGENTA;
      3'd5:    return GRB_R;
      3'd6:    return GRB_B;
      default: return GRB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_pattern_gen_pattern.sv
// Colour generation: stripe/bar counters tracking the current x, registered {G,R,B} output.
module vtg_pattern
  import video_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned STRIPE_W = 960,
  parameter int unsigned BAR_W    = 240
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_de,
  input  logic [CNT_W-1:0] i_x,
  input  vtg_mode_t        i_mode,
  input  logic [23:0]      i_solid,
  input  logic             i_odd,
  output logic [23:0]      o_grb
);

  localparam logic [CNT_W-1:0] C_S_LAST = CNT_W'(STRIPE_W - 1);
  localparam logic [CNT_W-1:0] C_B_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] r_scnt, r_bcnt;
  logic             r_sph;
  logic [2:0]       r_bidx;
  logic [CNT_W-1:0] w_scnt, w_bcnt;
  logic             w_sph;
  logic [2:0]       w_bidx;
  logic [23:0]      w_grb;

  // Registers hold the value for x+1; x==0 restarts the phase each line
  assign w_scnt = (i_x == '0) ? '0   : r_scnt;
  assign w_sph  = (i_x == '0) ? 1'b0 : r_sph;
  assign w_bcnt = (i_x == '0) ? '0   : r_bcnt;
  assign w_bidx = (i_x == '0) ? '0   : r_bidx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scnt <= '0;
      r_sph  <= 1'b0;
      r_bcnt <= '0;
      r_bidx <= '0;
    end else begin
      if (w_scnt == C_S_LAST) begin
        r_scnt <= '0;
        r_sph  <= ~w_sph;
      end else begin
        r_scnt <= w_scnt + CNT_W'(1);
        r_sph  <= w_sph;
      end
      if (w_bcnt == C_B_LAST) begin
        r_bcnt <= '0;
        r_bidx <= (w_bidx == 3'd7) ? w_bidx : w_bidx + 3'd1;
      end else begin
        r_bcnt <= w_bcnt + CNT_W'(1);
        r_bidx <= w_bidx;
      end
    end
  end

  always_comb begin
    w_grb = GRB_BLACK;
    if (i_de) begin
      case (i_mode)
        MODE_SOLID:  w_grb = i_solid;
        MODE_STRIPE: w_grb = w_sph ? GRB_B : GRB_G;
        MODE_BARS:   w_grb = bar_colour(w_bidx);
        MODE_TOGGLE: w_grb = i_odd ? ~i_solid : i_solid;
        default:     w_grb = GRB_BLACK;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_grb <= '0;
    else          o_grb <= w_grb;
  end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// HDMI-style timing + test-pattern source with hotplug-gated start.
// Optional frame counter built only when VTG_FRAME_CNT_EN is defined.
module video_timing_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned H_FP      = 88,
  parameter int unsigned H_SYNC    = 44,
  parameter int unsigned H_BP      = 148,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned V_FP      = 4,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 36,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned STRIPE_W  = 960,
  parameter int unsigned START_DLY = 100,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             hdmi_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             hotplug,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_grb,
  output logic             hdmi_de,
  output logic             hdmi_hs,
  output logic             hdmi_vs,
  output logic [7:0]       G_data_output,
  output logic [7:0]       R_data_output,
  output logic [7:0]       B_data_output,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int unsigned DLY_W   = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  localparam logic [CNT_W-1:0] C_H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

  vtg_state_t       r_state, w_state_nx;
  logic [CNT_W-1:0] r_h, r_v, w_h_nx, w_v_nx;
  logic [DLY_W-1:0] r_dly, w_dly_nx;
  logic             r_stop, w_stop_nx;
  logic             w_dly_done, w_h_last, w_v_last;

  logic             w_run, w_de, w_hs_on, w_vs_on, w_fs;
  vtg_mode_t        r_mode, w_mode;
  logic [23:0]      r_solid, w_solid;
  logic             r_tog, r_fpar, w_odd;
  logic [23:0]      w_grb;

  assign w_dly_done = (32'(r_dly) + 32'd1) >= START_DLY;
  assign w_h_last   = (r_h == C_H_LAST);
  assign w_v_last   = (r_v == C_V_LAST);

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_dly   <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_h     <= w_h_nx;
      r_v     <= w_v_nx;
      r_dly   <= w_dly_nx;
      r_stop  <= w_stop_nx;
    end
  end

  // An enable drop is remembered so the frame still ends at the v/h wrap
  always_comb begin
    w_state_nx = r_state;
    w_h_nx     = r_h;
    w_v_nx     = r_v;
    w_dly_nx   = r_dly;
    w_stop_nx  = r_stop;
    case (r_state)
      IDLE: begin
        w_h_nx    = '0;
        w_v_nx    = '0;
        w_dly_nx  = '0;
        w_stop_nx = 1'b0;
        if (enable && hotplug) w_state_nx = WAIT;
      end
      WAIT: begin
        if (!hotplug || !enable) begin
          w_state_nx = IDLE;
          w_dly_nx   = '0;
        end else if (w_dly_done) begin
          w_state_nx = RUN;
          w_h_nx     = '0;
          w_v_nx     = '0;
          w_dly_nx   = '0;
        end else begin
          w_dly_nx = r_dly + DLY_W'(1);
        end
      end
      RUN: begin
        if (!hotplug) begin
          w_state_nx = IDLE;
          w_h_nx     = '0;
          w_v_nx     = '0;
          w_stop_nx  = 1'b0;
        end else begin
          w_stop_nx = r_stop | ~enable;
          if (w_h_last) begin
            w_h_nx = '0;
            if (w_v_last) begin
              w_v_nx = '0;
              if (w_stop_nx) begin
                w_state_nx = IDLE;
                w_stop_nx  = 1'b0;
              end
            end else begin
              w_v_nx = r_v + CNT_W'(1);
            end
          end else begin
            w_h_nx = r_h + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_h_nx     = '0;
        w_v_nx     = '0;
        w_dly_nx   = '0;
        w_stop_nx  = 1'b0;
      end
    endcase
  end

  // Gating with hotplug makes a hotplug drop blank the very next output clock
  assign w_run   = (r_state == RUN) && hotplug;
  assign w_de    = w_run && (r_h < C_H_ACT) && (r_v < C_V_ACT);
  assign w_hs_on = w_run && (r_h >= C_H_SS) && (r_h < C_H_SE);
  assign w_vs_on = w_run && (r_v >= C_V_SS) && (r_v < C_V_SE);
  assign w_fs    = w_run && (r_h == '0) && (r_v == '0);

  assign w_mode  = w_fs ? vtg_mode_t'(mode) : r_mode;
  assign w_solid = w_fs ? solid_grb : r_solid;
  assign w_odd   = w_fs ? r_tog : r_fpar;

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_SOLID;
      r_solid <= '0;
      r_tog   <= 1'b0;
      r_fpar  <= 1'b0;
    end else if (w_fs) begin
      r_mode  <= w_mode;
      r_solid <= w_solid;
      r_fpar  <= r_tog;
      r_tog   <= ~r_tog;
    end
  end

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      hdmi_de     <= 1'b0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hdmi_de     <= w_de;
      hdmi_hs     <= w_hs_on ? HS_POL : ~HS_POL;
      hdmi_vs     <= w_vs_on ? VS_POL : ~VS_POL;
      pix_x       <= w_de ? r_h : '0;
      pix_y       <= w_de ? r_v : '0;
      frame_start <= w_fs;
    end
  end

  vtg_pattern #(
    .CNT_W    (CNT_W),
    .STRIPE_W (STRIPE_W),
    .BAR_W    (BAR_W)
  ) u_pattern (
    .i_clk   (hdmi_clk),
    .i_rst_n (rst_n),
    .i_de    (w_de),
    .i_x     (r_h),
    .i_mode  (w_mode),
    .i_solid (w_solid),
    .i_odd   (w_odd),
    .o_grb   (w_grb)
  );

  assign {G_data_output, R_data_output, B_data_output} = w_grb;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] r_fcnt;

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n)    r_fcnt <= '0;
    else if (w_fs) r_fcnt <= r_fcnt + 16'd1;
  end

  assign frame_cnt = r_fcnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen with reduced 22x7 timing.
module tb_video_timing_pattern_gen;

  localparam logic [23:0] SOLID = 24'h123456;
`ifdef VTG_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        hdmi_clk = 1'b0;
  logic        rst_n, enable, hotplug;
  logic [1:0]  mode;
  logic [23:0] solid_grb;
  logic        hdmi_de, hdmi_hs, hdmi_vs, frame_start;
  logic [7:0]  G_data_output, R_data_output, B_data_output;
  logic [11:0] pix_x, pix_y;
  logic [15:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                            24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  video_timing_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .STRIPE_W (4),  .START_DLY (5)
  ) dut (
    .hdmi_clk      (hdmi_clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .hotplug       (hotplug),
    .mode          (mode),
    .solid_grb     (solid_grb),
    .hdmi_de       (hdmi_de),
    .hdmi_hs       (hdmi_hs),
    .hdmi_vs       (hdmi_vs),
    .G_data_output (G_data_output),
    .R_data_output (R_data_output),
    .B_data_output (B_data_output),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .frame_start   (frame_start),
    .frame_cnt     (frame_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_col(input int x, input logic [1:0] m, input bit odd);
    case (m)
      2'd0:    return SOLID;
      2'd1:    return (((x / 4) % 2) == 0) ? 24'hFF0000 : 24'h0000FF;
      2'd2:    return (x / 2 < 8) ? bars[x / 2] : 24'h000000;
      default: return odd ? ~SOLID : SOLID;
    endcase
  endfunction

  task automatic wait_de(output int n);
    n = 0;
    while (hdmi_de !== 1'b1 && n < 100) begin
      @(negedge hdmi_clk);
      n++;
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input bit odd, input int fc, input int n,
                           input int chg_t, input logic [1:0] chg_m,
                           input int hp_t, input int en_t);
    for (int t = 0; t < n; t++) begin
      int h, v;
      bit ede;
      logic [23:0] ecol;
      h = t % 22;
      v = t / 22;
      ede = (h < 16) && (v < 4);
      ecol = ede ? exp_col(h, m, odd) : 24'h0;
      chk($sformatf("de t=%0d", t), 32'(hdmi_de), 32'(ede));
      chk($sformatf("hs t=%0d", t), 32'(hdmi_hs), 32'(!(h >= 18 && h < 20)));
      chk($sformatf("vs t=%0d", t), 32'(hdmi_vs), 32'(v != 5));
      chk($sformatf("grb t=%0d", t), 32'({G_data_output, R_data_output, B_data_output}), 32'(ecol));
      chk($sformatf("fs t=%0d", t), 32'(frame_start), 32'(t == 0));
      if (ede) begin
        chk($sformatf("px t=%0d", t), 32'(pix_x), 32'(h));
        chk($sformatf("py t=%0d", t), 32'(pix_y), 32'(v));
      end
      if (t == 0) chk("fcnt", 32'(frame_cnt), FC_EN ? 32'(fc) : 32'd0);
      if (t == chg_t) mode = chg_m;
      if (t == hp_t) hotplug = 1'b0;
      if (t == en_t) enable = 1'b0;
      @(negedge hdmi_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; hotplug = 1'b0; mode = 2'd0; solid_grb = SOLID;
    repeat (3) @(negedge hdmi_clk);
    chk("rst de", 32'(hdmi_de), 32'd0);
    chk("rst hs", 32'(hdmi_hs), 32'd1);
    chk("rst vs", 32'(hdmi_vs), 32'd1);
    chk("rst grb", 32'({G_data_output, R_data_output, B_data_output}), 32'd0);
    chk("rst pix", 32'({pix_x, pix_y}), 32'd0);
    chk("rst fs", 32'(frame_start), 32'd0);
    chk("rst fcnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge hdmi_clk);
    chk("idle de", 32'(hdmi_de), 32'd0);

    enable = 1'b1; hotplug = 1'b1;
    wait_de(n);
    chk("start latency", 32'(n), 32'd7);

    run_frame(2'd0, 1'b0, 1, 154, 44, 2'd2, -1, -1);  // A: solid, mode->bars at line 2
    run_frame(2'd2, 1'b1, 2, 154, 30, 2'd1, -1, -1);  // B: bars
    run_frame(2'd1, 1'b0, 3, 154, 30, 2'd3, -1, -1);  // C: stripes
    run_frame(2'd3, 1'b1, 4, 154, -1, 2'd0, -1, -1);  // D: toggle, odd
    run_frame(2'd3, 1'b0, 5, 28, -1, 2'd0, 27, -1);   // E: hotplug drop at (5,1)

    chk("hp de", 32'(hdmi_de), 32'd0);
    chk("hp hs", 32'(hdmi_hs), 32'd1);
    chk("hp vs", 32'(hdmi_vs), 32'd1);
    chk("hp grb", 32'({G_data_output, R_data_output, B_data_output}), 32'd0);
    hotplug = 1'b1;
    wait_de(n);
    chk("restart latency", 32'(n), 32'd7);

    run_frame(2'd3, 1'b1, 6, 154, -1, 2'd0, -1, 30);  // F: enable drop mid-frame
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("stop de i=%0d", i), 32'(hdmi_de), 32'd0);
      chk($sformatf("stop fs i=%0d", i), 32'(frame_start), 32'd0);
      @(negedge hdmi_clk);
    end
    chk("stop fcnt", 32'(frame_cnt), FC_EN ? 32'd6 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
